iic_oled_slave: RTL

IIC_OLED_SLAVE -- requirements
Module: iic_oled_slave

---
 rtl/iic_oled_slave.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/iic_oled_slave.sv
// Write-only IIC slave front end for an SSD1306-style OLED controller: address match,
// control byte D/C latch and payload byte delivery. Optional majority filter: IIC_SLAVE_GLITCH_FILTER_EN.
module iic_oled_slave #(
   parameter logic [7:0] SLAVE_ADDR = 8'h78
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_dc,
   output logic       busy,
   output logic       nack_err
);

   typedef enum logic [2:0] {
      StIdle, StAddr, StAddrAck, StCtrl, StCtrlAck, StData, StDataAck, StIgnore
   } state_e;

   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_lvl, sda_lvl;
   logic       scl_prev_q, sda_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_in};
         sda_sync_q <= {sda_sync_q[0], sda_in};
      end
   end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
   logic [1:0] scl_hist_q, sda_hist_q;
   logic       scl_filt_q, sda_filt_q;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   // Vote over the current synchronized sample and the two before it: +2 clk latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_hist_q <= 2'b11;
         sda_hist_q <= 2'b11;
         scl_filt_q <= 1'b1;
         sda_filt_q <= 1'b1;
      end else begin
         scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
         sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
         scl_filt_q <= maj3({scl_hist_q, scl_sync_q[1]});
         sda_filt_q <= maj3({sda_hist_q, sda_sync_q[1]});
      end
   end

   assign scl_lvl = scl_filt_q;
   assign sda_lvl = sda_filt_q;
`else
   assign scl_lvl = scl_sync_q[1];
   assign sda_lvl = sda_sync_q[1];
`endif

   logic scl_rise, scl_fall, start_det, stop_det;

   assign scl_rise  = scl_lvl & ~scl_prev_q;
   assign scl_fall  = ~scl_lvl & scl_prev_q;
   assign start_det = scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
   assign stop_det  = scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;

   state_e     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [7:0] byte_in;
   logic       dc_q, dc_d;
   logic       sda_oe_q, sda_oe_d;
   logic       byte_valid_q, byte_valid_d;
   logic [7:0] byte_data_q, byte_data_d;
   logic       byte_dc_q, byte_dc_d;
   logic       busy_q, busy_d;
   logic       nack_err_q, nack_err_d;

   assign byte_in = {shift_q, sda_lvl};

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      dc_d         = dc_q;
      sda_oe_d     = sda_oe_q;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      byte_dc_d    = byte_dc_q;
      busy_d       = busy_q;
      nack_err_d   = 1'b0;

      // Bus conditions win over any bit edge seen on the same clk.
      if (stop_det) begin
         state_d   = StIdle;
         bit_cnt_d = 3'd0;
         shift_d   = 7'd0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else if (start_det) begin
         state_d   = StAddr;
         bit_cnt_d = 3'd0;
         shift_d   = 7'd0;
         sda_oe_d  = 1'b0;
      end else begin
         unique case (state_q)
            StAddr, StCtrl, StData: begin
               if (scl_rise) begin
                  shift_d   = byte_in[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == StAddr) begin
                        if (byte_in == SLAVE_ADDR) begin
                           state_d = StAddrAck;
                           busy_d  = 1'b1;
                        end else begin
                           state_d    = StIgnore;
                           busy_d     = 1'b0;
                           nack_err_d = 1'b1;
                        end
                     end else if (state_q == StCtrl) begin
                        dc_d    = byte_in[6];
                        state_d = StCtrlAck;
                     end else begin
                        byte_data_d  = byte_in;
                        byte_dc_d    = dc_q;
                        byte_valid_d = 1'b1;
                        state_d      = StDataAck;
                     end
                  end
               end
            end
            // First SCL fall drives ACK, second releases it and moves on.
            StAddrAck, StCtrlAck, StDataAck: begin
               if (scl_fall) begin
                  sda_oe_d = ~sda_oe_q;
                  if (sda_oe_q) begin
                     state_d = (state_q == StAddrAck) ? StCtrl : StData;
                  end
               end
            end
            StIdle, StIgnore: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_prev_q   <= 1'b1;
         sda_prev_q   <= 1'b1;
         state_q      <= StIdle;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 7'd0;
         dc_q         <= 1'b0;
         sda_oe_q     <= 1'b0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= 8'h00;
         byte_dc_q    <= 1'b0;
         busy_q       <= 1'b0;
         nack_err_q   <= 1'b0;
      end else begin
         scl_prev_q   <= scl_lvl;
         sda_prev_q   <= sda_lvl;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         dc_q         <= dc_d;
         sda_oe_q     <= sda_oe_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
         byte_dc_q    <= byte_dc_d;
         busy_q       <= busy_d;
         nack_err_q   <= nack_err_d;
      end
   end

   assign sda_oe     = sda_oe_q;
   assign byte_valid = byte_valid_q;
   assign byte_data  = byte_data_q;
   assign byte_dc    = byte_dc_q;
   assign busy       = busy_q;
   assign nack_err   = nack_err_q;

endmodule
